audio_nios_sample_reader: RTL
=============================

Name: audio_nios_sample_reader

Overview:
- Avalon-MM read initiator that fetches 32-bit audio sample words from the single-port on-chip sample memory.
- Presents the words in order on a valid/ready stream toward the audio codec serializer.
- Sits between the on-chip memory slave port (fixed 1-cycle read latency, no waitrequest) and the audio output path.
- Software programs base, length and loop mode, then pulses start.

Parameters:
- ADDR_W, 16, word-address width of the memory port.
- MEM_WORDS, 40000, memory depth in words; the address wraps to 0 past MEM_WORDS-1.
- RD_LATENCY, 1, cycles from address/chipselect to valid readdata.
- FIFO_DEPTH, 4, output buffer entries; power of 2, must be >= RD_LATENCY+1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that launches a transfer; ignored while busy=1.
- abort  in  1  stops issuing reads and discards pending data.
- base_addr  in  ADDR_W  first word address; sampled on an accepted start.
- num_words  in  ADDR_W  transfer length in words; sampled on an accepted start.
- loop_en  in  1  restart at base after the last word; sampled on an accepted start.
- busy  out  1  high from an accepted start until the transfer finishes.
- done  out  1  one-cycle pulse at the end of a transfer.
- m_address  out  ADDR_W  memory word address.
- m_chipselect  out  1  read strobe.
- m_write  out  1  tied 0.
- m_byteenable  out  4  tied 4'hF.
- m_readdata  in  32  memory read data.
- smp_data  out  32  stream sample.
- smp_valid  out  1  stream valid.
- smp_ready  in  1  stream backpressure.

Behaviour:
- Reset values: busy=0, done=0, m_chipselect=0, m_address=0, smp_valid=0. FIFO is emptied, counters clear, FSM goes to IDLE. Reset mid-transfer drops all in-flight data.
- FSM states:
  - IDLE: on start, latch parameters. If num_words=0, go to FIN. Otherwise cur_addr=base_addr, remaining=num_words, go to RUN.
  - RUN: issue reads (rules below). When remaining hits 0 and loop_en=0, go to DRAIN. When remaining hits 0 and loop_en=1, reload cur_addr=base, remaining=num_words and stay in RUN with no bubble.
  - DRAIN: no new reads. Wait until in-flight=0 and FIFO empty, then go to FIN.
  - FIN: done=1 for exactly one cycle, busy=0 next cycle, return to IDLE.
- Read issue:
  - m_chipselect=1 only in RUN when (fifo_count + inflight) < FIFO_DEPTH.
  - Each issued cycle: m_address=cur_addr, cur_addr increments by 1 (MEM_WORDS-1 wraps to 0), remaining decrements by 1.
- Return path:
  - A RD_LATENCY-deep valid shift register tags each issued read.
  - The tagged m_readdata is pushed into the FIFO in the cycle its tag emerges.
  - The credit rule guarantees no overflow; a push into a full FIFO is an assertion failure.
- Stream:
  - smp_valid = FIFO not empty; smp_data = FIFO head.
  - Pop on smp_valid & smp_ready.
  - Push and pop in the same cycle leaves the count unchanged.
  - smp_data and smp_valid are held stable while smp_valid=1 and smp_ready=0.
- Throughput: with smp_ready=1 constantly, one word per cycle. First smp_valid appears RD_LATENCY+1 cycles after an accepted start.
- Abort (any state except IDLE):
  - Stop issuing reads and flush the FIFO.
  - Ignore returning in-flight data and wait for the tags to clear.
  - Then go to FIN, so done still pulses.
  - Abort with start in the same cycle: abort wins.
- start in the FIN cycle is ignored.

Decomposition:
- Shared package audio_nios_pkg:
  - sample_t (32-bit word).
  - FSM state enum {IDLE, RUN, DRAIN, FIN}.
  - Constants MEM_WORDS_DEFAULT=40000 and byteenable-all-ones.
- One sub-module, audio_nios_sync_fifo:
  - Parameterised width/depth, synchronous reset.
  - Push/pop ports, count, full, empty, flush.
  - Reused elsewhere in the audio path.

Test Plan:
- Memory preloaded with word i = 32'hA000_0000+i; base=10, num_words=5, smp_ready=1 -> smp_data A000000A..A000000E on consecutive cycles, single done pulse, busy low after it.
- base=39998, num_words=4 -> m_address 39998, 39999, 0, 1 and the data in that order.
- smp_ready=0 for 20 cycles mid-transfer -> at most FIFO_DEPTH words buffered, m_chipselect deasserts, no sample lost or duplicated, smp_data stable while stalled.
- loop_en=1, base=0, num_words=3, 10 pops -> words 0,1,2,0,1,2,0,1,2,0 with no bubble; abort then -> done pulses, smp_valid=0 after the flush, busy=0.
- num_words=0 -> no m_chipselect, done pulses within 2 cycles; start while busy -> ignored, original transfer completes unchanged.
- Synchronous reset asserted mid-RUN -> next cycle all outputs at reset values, no further smp_valid until a new start.

Source files
------------

// File: rtl/audio_nios_pkg.sv
// Shared types and constants for the audio sample fetch path.
package audio_nios_pkg;

  typedef logic [31:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  localparam int         MEM_WORDS_DEFAULT = 40000;
  localparam logic [3:0] BYTEEN_ALL        = 4'hF;

  // Next word address in a memory of 'words' entries, wrapping past the top.
  function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned words);
    return (addr + 1 >= words) ? 0 : addr + 1;
  endfunction

endpackage

// File: rtl/audio_nios_sync_fifo.sv
// Single-clock FIFO with count/full/empty and a synchronous flush.
module audio_nios_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign count    = count_reg;
  assign pop_data = mem[rd_ptr_reg];

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/audio_nios_sample_reader.sv
// Avalon-MM read initiator streaming sample words from on-chip memory to the codec path.
module audio_nios_sample_reader
  import audio_nios_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              loop_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [3:0]        m_byteenable,
  input  logic [31:0]       m_readdata,
  output logic [31:0]       smp_data,
  output logic              smp_valid,
  input  logic              smp_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
  logic [ADDR_W-1:0]   remaining_reg, remaining_next;
  logic [ADDR_W-1:0]   base_reg, base_next;
  logic [ADDR_W-1:0]   len_reg, len_next;
  logic                loop_reg, loop_next;
  logic                drop_reg, drop_next;
  logic [RD_LATENCY-1:0] tag_reg;

  logic                issue;
  logic                flush;
  logic                push;
  logic                pop;
  logic                abort_hit;
  logic                credit_ok;
  int                  inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  sample_t             fifo_head;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (tag_reg[i] ? 1 : 0);
    end
  end

  // Reads already in flight reserve a FIFO slot, so returning data can never overflow.
  assign credit_ok = (int'(fifo_count) + inflight) < FIFO_DEPTH;
  assign abort_hit = abort && (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    base_next      = base_reg;
    len_next       = len_reg;
    loop_next      = loop_reg;
    drop_next      = drop_reg;
    issue          = 1'b0;
    flush          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          base_next = base_addr;
          len_next  = num_words;
          loop_next = loop_en;
          if (num_words == '0) begin
            state_next = FIN;
          end else begin
            cur_addr_next  = base_addr;
            remaining_next = num_words;
            state_next     = RUN;
          end
        end
      end

      RUN: begin
        if (abort_hit) begin
          flush      = 1'b1;
          drop_next  = 1'b1;
          state_next = DRAIN;
        end else if (credit_ok) begin
          issue         = 1'b1;
          cur_addr_next = ADDR_W'(wrap_inc(32'(cur_addr_reg), MEM_WORDS));
          if (remaining_reg == ADDR_W'(1)) begin
            if (loop_reg) begin
              // Reload in the same cycle so looping playback has no gap.
              cur_addr_next  = base_reg;
              remaining_next = len_reg;
            end else begin
              remaining_next = '0;
              state_next     = DRAIN;
            end
          end else begin
            remaining_next = remaining_reg - ADDR_W'(1);
          end
        end
      end

      DRAIN: begin
        if (abort_hit) begin
          flush     = 1'b1;
          drop_next = 1'b1;
        end else if (inflight == 0 && fifo_empty) begin
          state_next = FIN;
        end
      end

      FIN: begin
        drop_next  = 1'b0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      base_reg      <= '0;
      len_reg       <= '0;
      loop_reg      <= 1'b0;
      drop_reg      <= 1'b0;
      tag_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      base_reg      <= base_next;
      len_reg       <= len_next;
      loop_reg      <= loop_next;
      drop_reg      <= drop_next;
      tag_reg[0]    <= issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_reg[i] <= tag_reg[i-1];
      end
    end
  end

  // Data returning after an abort belongs to a cancelled transfer and is discarded.
  assign push = tag_reg[RD_LATENCY-1] & ~drop_reg & ~flush;
  assign pop  = ~fifo_empty & smp_ready;

  audio_nios_sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .srst     (reset),
    .flush    (flush),
    .push     (push),
    .push_data(m_readdata),
    .pop      (pop),
    .pop_data (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (!fifo_full);
    end
  end

  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FIN);
  assign m_chipselect = issue;
  assign m_address    = cur_addr_reg;
  assign m_write      = 1'b0;
  assign m_byteenable = BYTEEN_ALL;
  assign smp_valid    = ~fifo_empty;
  assign smp_data     = fifo_head;

endmodule
